// File: rtl/dmem_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sram_bridge
// Purpose  : Adapts the M-stage data port of the datapath to an SRAM-like
//            req / addr_ok / data_ok bus. It stalls the pipeline while an
//            access is outstanding. It also keeps the returned load data
//            until the pipeline moves on, so a stalled M stage never issues
//            the same access twice.
// Ports    : clk, rst                    - clock, synchronous active-high reset
//            data_sram_enM/wenM/waddrM/wdataM/rdataM - datapath M-stage port
//            except_logicM               - M-stage exception (blocks new starts)
//            longest_stall               - global stall from the hazard unit
//            d_stall                     - data-side stall request to hazard unit
//            data_req/wr/size/addr/wdata - bus request channel
//            data_addr_ok/data_ok/rdata  - bus response channel
// Revision : 1.0 - initial release
// ============================================================================
module dmem_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_enM,
    input  logic [3:0]  data_sram_wenM,
    input  logic [31:0] data_sram_waddrM,
    input  logic [31:0] data_sram_wdataM,
    input  logic        except_logicM,
    input  logic        longest_stall,
    output logic [31:0] data_sram_rdataM,
    output logic        d_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata_buf;

    logic        w_start;
    logic        w_req;
    logic        w_stall;
    logic        w_wr;
    logic [1:0]  w_size;
    logic [1:0]  w_lsb;
    logic        w_unused_addr_lsb;

    // The datapath's own low address bits are not used. Byte and halfword
    // lanes are derived from the write enables instead.
    assign w_unused_addr_lsb = ^data_sram_waddrM[1:0];

    assign w_start = data_sram_enM & ~except_logicM;

    // Decode the request fields from the live M-stage inputs. These values
    // are only driven onto the bus in the first request cycle (IDLE). In
    // later cycles the latched copies are shown instead.
    always_comb begin
        w_wr   = 1'b1;
        w_size = 2'd2;
        w_lsb  = 2'd0;
        case (data_sram_wenM)
            4'b0000: w_wr = 1'b0;
            4'b0001: begin w_size = 2'd0; w_lsb = 2'd0; end
            4'b0010: begin w_size = 2'd0; w_lsb = 2'd1; end
            4'b0100: begin w_size = 2'd0; w_lsb = 2'd2; end
            4'b1000: begin w_size = 2'd0; w_lsb = 2'd3; end
            4'b0011: begin w_size = 2'd1; w_lsb = 2'd0; end
            4'b1100: begin w_size = 2'd1; w_lsb = 2'd2; end
            default: begin w_size = 2'd2; w_lsb = 2'd0; end
        endcase
    end

    // Next-state and control. d_stall deliberately ignores longest_stall,
    // because longest_stall is itself derived from d_stall.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req   = w_start;
                w_stall = w_start;
                if (w_start)
                    w_state_next = data_addr_ok ? S_WAIT : S_REQ;
            end
            S_REQ: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (data_addr_ok)
                    w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_stall = ~data_data_ok;
                if (data_data_ok)
                    w_state_next = longest_stall ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (!longest_stall)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr        <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rdata_buf <= 32'd0;
        end else begin
            r_state <= w_state_next;
            // Capture the request on its first cycle. The bus then sees stable
            // fields even if the M-stage inputs change while we wait for addr_ok.
            if (r_state == S_IDLE && w_start) begin
                r_wr    <= w_wr;
                r_size  <= w_size;
                r_addr  <= {data_sram_waddrM[31:2], w_lsb};
                r_wdata <= data_sram_wdataM;
            end
            if (r_state == S_WAIT && data_data_ok)
                r_rdata_buf <= data_rdata;
        end
    end

    always_comb begin
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        d_stall    = 1'b0;
        if (!rst) begin
            data_req = w_req;
            d_stall  = w_stall;
            if (r_state == S_IDLE) begin
                data_wr    = w_wr;
                data_size  = w_size;
                data_addr  = {data_sram_waddrM[31:2], w_lsb};
                data_wdata = data_sram_wdataM;
            end else begin
                data_wr    = r_wr;
                data_size  = r_size;
                data_addr  = r_addr;
                data_wdata = r_wdata;
            end
        end
    end

    assign data_sram_rdataM = (r_state == S_WAIT && data_data_ok) ? data_rdata
                                                                   : r_rdata_buf;

endmodule
`default_nettype wire

// File: tb/tb_dmem_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_sram_bridge
// Purpose  : Directed self-checking bench for dmem_sram_bridge. Inputs change
//            1 time unit after each rising edge. Outputs are checked 1 time
//            unit later, well clear of both clock edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_sram_bridge;

    logic        clk;
    logic        rst;
    logic        data_sram_enM;
    logic [3:0]  data_sram_wenM;
    logic [31:0] data_sram_waddrM;
    logic [31:0] data_sram_wdataM;
    logic        except_logicM;
    logic        longest_stall;
    logic [31:0] data_sram_rdataM;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_sram_bridge dut (
        .clk              (clk),
        .rst              (rst),
        .data_sram_enM    (data_sram_enM),
        .data_sram_wenM   (data_sram_wenM),
        .data_sram_waddrM (data_sram_waddrM),
        .data_sram_wdataM (data_sram_wdataM),
        .except_logicM    (except_logicM),
        .longest_stall    (longest_stall),
        .data_sram_rdataM (data_sram_rdataM),
        .d_stall          (d_stall),
        .data_req         (data_req),
        .data_wr          (data_wr),
        .data_size        (data_size),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .data_addr_ok     (data_addr_ok),
        .data_data_ok     (data_data_ok),
        .data_rdata       (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        data_sram_enM = 1'b0;
        data_sram_wenM = 4'b0000;
        data_sram_waddrM = 32'd0;
        data_sram_wdataM = 32'd0;
        except_logicM = 1'b0;
        longest_stall = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = 32'd0;
        tick();
        tick();

        // ---- Reset: outputs forced low even with a request present ----
        data_sram_enM = 1'b1;
        #1;
        chk("rst_req",    {31'd0, data_req}, 32'd0);
        chk("rst_dstall", {31'd0, d_stall},  32'd0);
        chk("rst_rdata",  data_sram_rdataM,  32'd0);
        data_sram_enM = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // ---- 1. Zero-wait load ----
        data_sram_enM = 1'b1; data_sram_wenM = 4'b0000;
        data_sram_waddrM = 32'h1000_0006; data_addr_ok = 1'b1;
        #1;
        chk("t1_req",    {31'd0, data_req}, 32'd1);
        chk("t1_wr",     {31'd0, data_wr},  32'd0);
        chk("t1_size",   {30'd0, data_size}, 32'd2);
        chk("t1_addr",   data_addr, 32'h1000_0004);
        chk("t1_dstall", {31'd0, d_stall}, 32'd1);
        tick();
        data_sram_enM = 1'b0; data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_c1_dstall", {31'd0, d_stall},  32'd0);
        chk("t1_c1_req",    {31'd0, data_req}, 32'd0);
        chk("t1_c1_rdata",  data_sram_rdataM, 32'hDEAD_BEEF);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'd0;
        #1;
        chk("t1_hold_rdata", data_sram_rdataM, 32'hDEAD_BEEF);

        // ---- 2. Byte store with waits; inputs disturbed after cycle 0 ----
        data_sram_enM = 1'b1; data_sram_wenM = 4'b0100;
        data_sram_waddrM = 32'h0000_0010; data_sram_wdataM = 32'h00AB_0000;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            #1;
            chk($sformatf("t2_req%0d", i),    {31'd0, data_req},  32'd1);
            chk($sformatf("t2_wr%0d", i),     {31'd0, data_wr},   32'd1);
            chk($sformatf("t2_size%0d", i),   {30'd0, data_size}, 32'd0);
            chk($sformatf("t2_addr%0d", i),   data_addr,  32'h0000_0012);
            chk($sformatf("t2_wdata%0d", i),  data_wdata, 32'h00AB_0000);
            chk($sformatf("t2_dstall%0d", i), {31'd0, d_stall}, 32'd1);
            tick();
            data_sram_wenM = 4'b0000;
            data_sram_waddrM = 32'hFFFF_FFFF;
            data_sram_wdataM = 32'h1111_1111;
        end
        data_addr_ok = 1'b0;
        for (int i = 4; i < 6; i++) begin
            #1;
            chk($sformatf("t2_wait_req%0d", i),    {31'd0, data_req}, 32'd0);
            chk($sformatf("t2_wait_dstall%0d", i), {31'd0, d_stall},  32'd1);
            tick();
        end
        data_data_ok = 1'b1; data_rdata = 32'h0000_00A5; data_sram_enM = 1'b0;
        #1;
        chk("t2_dok_dstall", {31'd0, d_stall}, 32'd0);
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("t2_after_dstall", {31'd0, d_stall}, 32'd0);
        chk("t2_after_req",    {31'd0, data_req}, 32'd0);
        chk("t2_store_buf",    data_sram_rdataM, 32'h0000_00A5);

        // ---- 3. Halfword store on upper lanes ----
        data_sram_enM = 1'b1; data_sram_wenM = 4'b1100;
        data_sram_waddrM = 32'h0000_0020; data_sram_wdataM = 32'hBEEF_0000;
        data_addr_ok = 1'b1;
        #1;
        chk("t3_wr",   {31'd0, data_wr},   32'd1);
        chk("t3_size", {30'd0, data_size}, 32'd1);
        chk("t3_addr", data_addr, 32'h0000_0022);
        tick();
        data_sram_enM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;

        // ---- 4. External stall holds the load result in DONE ----
        data_sram_enM = 1'b1; data_sram_wenM = 4'b0000;
        data_sram_waddrM = 32'h0000_0040; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        longest_stall = 1'b1;
        #1;
        chk("t4_dok_rdata", data_sram_rdataM, 32'h1234_5678);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4_done_req%0d", i),    {31'd0, data_req}, 32'd0);
            chk($sformatf("t4_done_dstall%0d", i), {31'd0, d_stall},  32'd0);
            chk($sformatf("t4_done_rdata%0d", i),  data_sram_rdataM, 32'h1234_5678);
            tick();
        end
        longest_stall = 1'b0;
        #1;
        chk("t4_release_req", {31'd0, data_req}, 32'd0);
        tick();
        data_sram_enM = 1'b0;
        #1;
        chk("t4_idle_req",   {31'd0, data_req}, 32'd0);
        chk("t4_idle_rdata", data_sram_rdataM, 32'h1234_5678);

        // ---- 5. Exception blocks a start; exception in REQ does not ----
        data_sram_enM = 1'b1; except_logicM = 1'b1; data_sram_waddrM = 32'h0000_0050;
        #1;
        chk("t5_exc_req",    {31'd0, data_req}, 32'd0);
        chk("t5_exc_dstall", {31'd0, d_stall},  32'd0);
        tick();
        except_logicM = 1'b0;
        #1;
        chk("t5_start_req", {31'd0, data_req}, 32'd1);
        tick();
        except_logicM = 1'b1;
        #1;
        chk("t5_req_exc_req",    {31'd0, data_req}, 32'd1);
        chk("t5_req_exc_dstall", {31'd0, d_stall},  32'd1);
        chk("t5_req_exc_addr",   data_addr, 32'h0000_0050);
        tick();
        data_addr_ok = 1'b1;
        #1;
        chk("t5_aok_req", {31'd0, data_req}, 32'd1);
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        data_sram_enM = 1'b0;
        #1;
        chk("t5_dok_rdata",  data_sram_rdataM, 32'hCAFE_F00D);
        chk("t5_dok_dstall", {31'd0, d_stall}, 32'd0);
        tick();
        data_data_ok = 1'b0; except_logicM = 1'b0;

        // ---- 6. Reset during WAIT, then a stray data_ok ----
        data_sram_enM = 1'b1; data_sram_waddrM = 32'h0000_0080; data_addr_ok = 1'b1;
        tick();
        data_sram_enM = 1'b0; data_addr_ok = 1'b0;
        #1;
        chk("t6_wait_dstall", {31'd0, d_stall}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_req",    {31'd0, data_req}, 32'd0);
        chk("t6_rst_dstall", {31'd0, d_stall},  32'd0);
        tick();
        rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
        #1;
        chk("t6_late_dstall", {31'd0, d_stall},  32'd0);
        chk("t6_late_req",    {31'd0, data_req}, 32'd0);
        chk("t6_late_rdata",  data_sram_rdataM, 32'd0);
        tick();
        data_data_ok = 1'b0; data_rdata = 32'd0;
        #1;
        chk("t6_buf_zero", data_sram_rdataM, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
